// File: rtl/mul_iter_pkg.sv
// Shared types and helpers for the iterative shift-add multiplier.
// State enum, iteration count and operand magnitude extraction.
package mul_iter_pkg;

  localparam int MAX_W = 256;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    DONE
  } state_t;

  function automatic int iter_f(input int w, input int s);
    return w / s;
  endfunction

  // value arrives sign-extended in signed mode, zero-extended otherwise
  function automatic logic [MAX_W-1:0] abs_ext(
    input logic [MAX_W-1:0] value,
    input logic             signed_mode
  );
    if (signed_mode && value[MAX_W-1])
      return ~value + 1'b1;
    return value;
  endfunction

endpackage

// File: rtl/mul_iter_step.sv
// One shift-add iteration: o_acc = i_acc + i_mcand * i_bits.
// Ports: i_mcand/i_acc/o_acc are 2*WIDTH+STEP wide, i_bits STEP wide.
module mul_iter_step #(
  parameter  int WIDTH = 64,
  parameter  int STEP  = 2,
  localparam int AW    = 2 * WIDTH + STEP
) (
  input  logic [AW-1:0]   i_mcand,
  input  logic [AW-1:0]   i_acc,
  input  logic [STEP-1:0] i_bits,
  output logic [AW-1:0]   o_acc
);

  logic [AW-1:0] w_part;

  always_comb begin
    w_part = '0;
    for (int j = 0; j < STEP; j++) begin
      if (i_bits[j])
        w_part = w_part + (i_mcand << j);
    end
  end

  assign o_acc = i_acc + w_part;

endmodule

// File: rtl/mul_iter.sv
// Multi-cycle signed/unsigned multiplier, STEP bits per cycle,
// valid/ready on both sides. Ports: clk, rst, in_valid/in_ready,
// a, b, signed_mode, out_valid/out_ready, result, busy.
// MUL_ITER_EARLY_TERM_EN: stop once the multiplier is exhausted
// and expose the iteration count on cycles.
module mul_iter
  import mul_iter_pkg::*;
#(
  parameter  int WIDTH = 64,
  parameter  int STEP  = 2,
  localparam int ITER  = iter_f(WIDTH, STEP),
  localparam int CW    = $clog2(ITER + 1)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  input  logic               signed_mode,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] result,
`ifdef MUL_ITER_EARLY_TERM_EN
  output logic [CW-1:0]      cycles,
`endif
  output logic               busy
);

  localparam int AW = 2 * WIDTH + STEP;
  localparam int MW = WIDTH + 1;
  localparam int PW = 2 * WIDTH;

  state_t             r_state;
  state_t             w_state_nx;
  logic [AW-1:0]      r_mcand;
  logic [MW-1:0]      r_mplier;
  logic [AW-1:0]      r_acc;
  logic [AW-1:0]      w_acc_nx;
  logic               r_neg;
  logic [CW-1:0]      r_cnt;
  logic               r_fin;
  logic [PW-1:0]      r_result;
  logic [PW-1:0]      w_prod;
  logic               w_accept;
  logic               w_last;
  logic [MAX_W-1:0]   w_ext_a;
  logic [MAX_W-1:0]   w_ext_b;
  logic [MW-1:0]      w_mag_a;
  logic [MW-1:0]      w_mag_b;
`ifdef MUL_ITER_EARLY_TERM_EN
  logic [CW-1:0]      r_cycles;
`endif

  assign w_ext_a = {{(MAX_W-WIDTH){signed_mode & a[WIDTH-1]}}, a};
  assign w_ext_b = {{(MAX_W-WIDTH){signed_mode & b[WIDTH-1]}}, b};
  assign w_mag_a = MW'(abs_ext(w_ext_a, signed_mode));
  assign w_mag_b = MW'(abs_ext(w_ext_b, signed_mode));

  assign w_accept = in_valid && in_ready;
  assign w_prod   = r_acc[PW-1:0];

  // last iteration this cycle: count exhausted, or no multiplier left
`ifdef MUL_ITER_EARLY_TERM_EN
  assign w_last = (r_cnt == CW'(ITER - 1)) ||
                  ((r_mplier >> STEP) == '0);
`else
  assign w_last = (r_cnt == CW'(ITER - 1));
`endif

  mul_iter_step #(
    .WIDTH (WIDTH),
    .STEP  (STEP)
  ) u_step (
    .i_mcand (r_mcand),
    .i_acc   (r_acc),
    .i_bits  (r_mplier[STEP-1:0]),
    .o_acc   (w_acc_nx)
  );

  always_ff @(posedge clk) begin
    if (rst)
      r_state <= IDLE;
    else
      r_state <= w_state_nx;
  end

  always_comb begin
    w_state_nx = r_state;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    busy       = 1'b0;
    unique case (r_state)
      IDLE: begin
        in_ready = !rst;
        if (in_valid && !rst)
          w_state_nx = CALC;
      end
      CALC: begin
        busy = 1'b1;
        if (r_fin)
          w_state_nx = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready)
          w_state_nx = IDLE;
      end
      default: w_state_nx = IDLE;
    endcase
  end

  // CALC runs the iterations, then one extra cycle applies the sign
  always_ff @(posedge clk) begin
    if (rst) begin
      r_mcand  <= '0;
      r_mplier <= '0;
      r_acc    <= '0;
      r_neg    <= 1'b0;
      r_cnt    <= '0;
      r_fin    <= 1'b0;
      r_result <= '0;
`ifdef MUL_ITER_EARLY_TERM_EN
      r_cycles <= '0;
`endif
    end else if (w_accept) begin
      r_mcand  <= AW'(w_mag_a);
      r_mplier <= w_mag_b;
      r_acc    <= '0;
      r_neg    <= signed_mode & (a[WIDTH-1] ^ b[WIDTH-1]);
      r_cnt    <= '0;
      r_fin    <= 1'b0;
    end else if (r_state == CALC) begin
      if (r_fin) begin
        r_result <= r_neg ? (~w_prod + 1'b1) : w_prod;
`ifdef MUL_ITER_EARLY_TERM_EN
        r_cycles <= r_cnt;
`endif
      end else begin
        r_acc    <= w_acc_nx;
        r_mcand  <= r_mcand << STEP;
        r_mplier <= r_mplier >> STEP;
        r_cnt    <= r_cnt + 1'b1;
        r_fin    <= w_last;
      end
    end
  end

  assign result = r_result;
`ifdef MUL_ITER_EARLY_TERM_EN
  assign cycles = r_cycles;
`endif

endmodule
